// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the I2C EEPROM target.
// Imported by the bus front end and the target top.
package i2c_pkg;

  localparam logic [3:0] I2C_DEV_TYPE = 4'b1010;
  localparam int         BIT_CNT_W    = 4;

  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    AHI,
    AHI_ACK,
    ALO,
    ALO_ACK,
    WDAT,
    WDAT_ACK,
    RDAT,
    RDAT_ACK
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection.
// Events are decoded from the two oldest synchronizer stages.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_new;
  logic                   scl_old;
  logic                   sda_new;
  logic                   sda_old;

  // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
    end
  end

  assign scl_new  = scl_q[SYNC_STAGES-2];
  assign scl_old  = scl_q[SYNC_STAGES-1];
  assign sda_new  = sda_q[SYNC_STAGES-2];
  assign sda_old  = sda_q[SYNC_STAGES-1];

  assign scl_rise = scl_new & ~scl_old;
  assign scl_fall = ~scl_new & scl_old;
  assign start    = scl_new & scl_old & ~sda_new & sda_old;
  assign stop     = scl_new & scl_old & sda_new & ~sda_old;
  assign sda_s    = sda_new;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM target with 16-bit byte pointer.
// Bus transfers become single-cycle strobes on a sync byte memory.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [3:0] DEV_TYPE    = I2C_DEV_TYPE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  dev_addr,
  input  logic        SCL,
  inout  wire         SDA,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;
  logic sda_s;

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shreg;
  logic [15:0]          pointer;
  logic                 sda_oe;
  logic                 rd;
  logic                 rd_pend;
  logic                 rx_state;
  logic                 byte_done;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (SCL),
    .sda     (SDA),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop),
    .sda_s   (sda_s)
  );

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign rx_state  = (state == DEV) || (state == AHI) ||
                     (state == ALO) || (state == WDAT);
  assign byte_done = rx_state && scl_fall && (bit_cnt == BYTE_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      pointer   <= '0;
      sda_oe    <= 1'b0;
      rd        <= 1'b0;
      rd_pend   <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      rd_pend <= mem_re;
      if (rd_pend) shreg <= mem_rdata;
      if (start) begin
        state   <= DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (rx_state && scl_rise && bit_cnt != BYTE_BITS) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 1'b1;
        end
        unique case (state)
          IDLE: ;
          DEV: if (byte_done) begin
            if (shreg[7:1] == {DEV_TYPE, dev_addr}) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rd     <= shreg[0];
              state  <= DEV_ACK;
              // Pointer advances at issue so aborted reads still count.
              if (shreg[0]) begin
                mem_re   <= 1'b1;
                mem_addr <= pointer;
                pointer  <= pointer + 16'd1;
              end
            end else begin
              state <= IDLE;
            end
          end
          DEV_ACK: if (scl_fall) begin
            if (rd) begin
              sda_oe  <= ~shreg[7];
              bit_cnt <= BIT_CNT_W'(1);
              state   <= RDAT;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= AHI;
            end
          end
          AHI: if (byte_done) begin
            sda_oe <= 1'b1;
            state  <= AHI_ACK;
          end
          AHI_ACK: if (scl_fall) begin
            sda_oe        <= 1'b0;
            pointer[15:8] <= shreg;
            bit_cnt       <= '0;
            state         <= ALO;
          end
          ALO: if (byte_done) begin
            sda_oe <= 1'b1;
            state  <= ALO_ACK;
          end
          ALO_ACK: if (scl_fall) begin
            sda_oe       <= 1'b0;
            pointer[7:0] <= shreg;
            bit_cnt      <= '0;
            state        <= WDAT;
          end
          WDAT: if (byte_done) begin
            sda_oe    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= pointer;
            mem_wdata <= shreg;
            pointer   <= pointer + 16'd1;
            state     <= WDAT_ACK;
          end
          WDAT_ACK: if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= WDAT;
          end
          RDAT: if (scl_fall) begin
            if (bit_cnt == '0) begin
              sda_oe  <= ~shreg[7];
              bit_cnt <= BIT_CNT_W'(1);
            end else if (bit_cnt == BYTE_BITS) begin
              sda_oe <= 1'b0;
              state  <= RDAT_ACK;
            end else begin
              sda_oe  <= ~shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          RDAT_ACK: if (scl_rise) begin
            if (!sda_s) begin
              mem_re   <= 1'b1;
              mem_addr <= pointer;
              pointer  <= pointer + 16'd1;
              bit_cnt  <= '0;
              state    <= RDAT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

I2C target that emulates a 24Cxx-style serial EEPROM with a 16-bit byte address, backed by an external synchronous byte memory. It is the bus-side counterpart of the team's I2C EEPROM master. It decodes START, control, address and data phases, drives ACK and read data on SDA, and converts bus writes and reads into single-cycle memory strobes. Typical uses are as a bench/FPGA stand-in for a real EEPROM or as a register-file access port.

## Interface
- `DEV_TYPE`, default 4'b1010: upper four bits of the control byte matched by the target.
- `SYNC_STAGES`, default 2: synchronizer depth on SCL and SDA inputs, ≥2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dev_addr`  in  3  strap address; matched against control bits [3:1].
- `SCL`  in  1  bus clock, sampled only.
- `SDA`  inout  1  open-drain; driven 0 when `sda_oe`=1, else `1'bz`; never driven 1.
- `mem_addr`  out  16  byte address for `mem_we`/`mem_re`.
- `mem_wdata`  out  8  write data.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe; `mem_rdata` valid the following cycle.
- `mem_rdata`  in  8  read data.
- `busy`  out  1  high from address match until STOP, repeated START, or master NACK.

## Operation
- Bus front end: SCL/SDA pass through `SYNC_STAGES` flops. Edge events come from the last two stages.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - `scl_rise` / `scl_fall`: SCL edges.
- FSM states: IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK.
- START, including repeated START, from any state: clear bit counter, go to DEV. STOP from any state: release SDA, go to IDLE, clear `busy`. START/STOP take priority over any `scl_rise` or `scl_fall` in the same cycle.
- Receiving states (DEV, AHI, ALO, WDAT):
  - Shift SDA in MSB-first on `scl_rise`.
  - After the 8th bit, the next `scl_fall` enters the ACK state.
- DEV byte:
  - If control[7:1] ≠ {DEV_TYPE, dev_addr}: no ACK, go to IDLE and ignore the bus until the next START.
  - If it matches: ACK and set `busy`. Bit0=0 → AHI. Bit0=1 → pulse `mem_re` at `pointer` during DEV_ACK, then RDAT. This is a current-address read.
- AHI/ALO: after ACK, load `pointer[15:8]` / `pointer[7:0]`. After ALO_ACK, go to WDAT.
- WDAT: on byte completion, drive ACK and pulse `mem_we` once with `mem_addr`=`pointer`, `mem_wdata`=byte. Then `pointer`+1.
- RDAT:
  - Load the shift register from `mem_rdata`.
  - Present the MSB on SDA after the `scl_fall` that ends the preceding ACK. Each later bit goes out on `scl_fall`; bit=0 → `sda_oe`=1.
  - After 8 bits, release SDA and sample the master's ACK on `scl_rise`.
  - ACK (SDA=0): `pointer`+1, pulse `mem_re` at the new pointer, return to RDAT.
  - NACK: go to IDLE and clear `busy`.
- Pointer arithmetic: 16-bit, wraps 0xFFFF→0x0000. A dropped (NACKed or aborted) read still counts as read.
- A data byte interrupted by START/STOP is discarded: no `mem_we`.

## Timing
- Reset values:
  - `sda_oe`=0 (SDA released).
  - `pointer`=0x0000, FSM=IDLE, `busy`=0.
  - `mem_we`=`mem_re`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted mid-transfer releases SDA asynchronously.
- `sda_oe` changes only in the cycle after a detected `scl_fall`. The only exception is release on STOP or reset.
- ACK drive: asserted one cycle after the `scl_fall` following the 8th bit; released one cycle after the next `scl_fall`.
- `mem_we`/`mem_re`: exactly one cycle per byte. `mem_re` is issued at least 2 cycles before the first bit is driven.
- Bus requirement: SCL high and low phases each ≥ `SYNC_STAGES`+3 clk cycles; SDA must be stable ≥1 clk cycle around SCL edges.

## Structure
- Package `i2c_pkg`:
  - constant `I2C_DEV_TYPE` = 4'b1010;
  - FSM state enum;
  - bit-count width.
- Sub-module `i2c_bus_sync`: synchronizers plus edge, START and STOP detection. The FSM, shift register and pointer live in the top.

## Test plan
- Byte write, `dev_addr`=3'b010, bus at 16 clk per SCL phase. START, 0xA4, 0x12, 0x34, 0x5A, 0xC3, STOP → ACK on all 5 bytes; `mem_we` at (0x1234, 0x5A) then (0x1235, 0xC3); `busy` drops after STOP.
- Random read, memory preloaded [0x1234]=0x96, [0x1235]=0x3C. Write 0xA4, 0x12, 0x34; Sr; 0xA5; master ACK, then NACK → bytes 0x96, 0x3C on SDA; `mem_re` at 0x1234, then 0x1235 (second strobe after the master ACK); a following current-address read returns [0x1236].
- Address mismatch: control 0xA0 with `dev_addr`=3'b010 → SDA stays released on the 9th clock; no `mem_we`/`mem_re`; `busy`=0; the next valid START works.
- Wrap: pointer 0xFFFF, write 0x11, 0x22 → `mem_we` at 0xFFFF, then 0x0000.
- Abort: STOP after 4 bits of a WDAT byte → no `mem_we`, SDA released, IDLE; the following write completes normally.
- Reset while driving ACK → SDA released in the same cycle, `pointer`=0, FSM=IDLE.
